// File: rtl/uart_232_rx.sv
// RS-232 receiver, 8N1, LSB first. Synchronises the serial line, detects the
// start edge, samples mid-bit at a selectable baud and strobes done or frame_err.
module uart_232_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    input  logic [2:0] bit_set,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [17:0] BT_9600   = 18'(CLK_FREQ / 9600);
    localparam logic [17:0] BT_19200  = 18'(CLK_FREQ / 19200);
    localparam logic [17:0] BT_38400  = 18'(CLK_FREQ / 38400);
    localparam logic [17:0] BT_57600  = 18'(CLK_FREQ / 57600);
    localparam logic [17:0] BT_115200 = 18'(CLK_FREQ / 115200);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [17:0] bit_cnt_q, bit_cnt_d;
    logic [17:0] bit_time_q, bit_time_d;
    logic [17:0] bit_time_sel;
    logic [17:0] half_time;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        rx_m_q, rx_s_q, rx_d_q;
    logic        fall;

    // Two-flop synchroniser plus one delay flop for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            rx_m_q <= uart_rx;
            rx_s_q <= rx_m_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign fall = rx_d_q & ~rx_s_q;

    always_comb begin
        case (bit_set)
            3'd1:    bit_time_sel = BT_19200;
            3'd2:    bit_time_sel = BT_38400;
            3'd3:    bit_time_sel = BT_57600;
            3'd4:    bit_time_sel = BT_115200;
            default: bit_time_sel = BT_9600;
        endcase
    end

    assign half_time = {1'b0, bit_time_q[17:1]};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 18'd1;
        bit_time_d = bit_time_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            StIdle: begin
                bit_cnt_d = 18'd0;
                if (fall) begin
                    state_d    = StStart;
                    bit_time_d = bit_time_sel;
                end
            end
            StStart: begin
                if (bit_cnt_q == half_time - 18'd1) begin
                    bit_cnt_d = 18'd0;
                    bit_idx_d = 3'd0;
                    // Line back high at mid-start means it was a glitch.
                    state_d   = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_cnt_q == bit_time_q - 18'd1) begin
                    bit_cnt_d          = 18'd0;
                    shreg_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_cnt_q == bit_time_q - 18'd1) begin
                    bit_cnt_d = 18'd0;
                    state_d   = StIdle;
                    if (rx_s_q) begin
                        data_d = shreg_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 18'd0;
            bit_time_q <= 18'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_time_q <= bit_time_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data      = data_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_232_rx.sv
// Scoreboard bench for uart_232_rx: a serial driver queues expected results,
// a monitor pops and compares on every done/frame_err strobe.
module tb_uart_232_rx;

    // Scaled-down clock keeps 9600-baud frames short.
    localparam int unsigned CLK_FREQ = 5_000_000;

    logic       clk;
    logic       reset_n;
    logic       uart_rx;
    logic [2:0] bit_set;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       busy;

    uart_232_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rx   (uart_rx),
        .bit_set   (bit_set),
        .data      (data),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] b;
        bit         err;
        int         start;
        int         lat;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic       done_prev = 1'b0;
    logic       ferr_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_bit_time(input int bs);
        int baud;
        case (bs)
            1:       baud = 19200;
            2:       baud = 38400;
            3:       baud = 57600;
            4:       baud = 115200;
            default: baud = 9600;
        endcase
        return CLK_FREQ / baud;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        int   lat;
        if (reset_n) begin
            if (done && frame_err) check("done_and_ferr_together", 1, 0);
            if (done && done_prev) check("done_width", 2, 1);
            if (frame_err && ferr_prev) check("ferr_width", 2, 1);
            if (done || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", {done, frame_err}, 0);
                end else begin
                    e   = q.pop_front();
                    lat = cyc - e.start;
                    check("strobe_kind", int'(frame_err), int'(e.err));
                    total++;
                    if (lat < e.lat - 1 || lat > e.lat + 1) begin
                        bad++;
                        $display("FAIL latency: got %0d expected %0d+-1", lat, e.lat);
                    end
                    if (!e.err) begin
                        check("data", int'(data), int'(e.b));
                        last_good = e.b;
                    end else begin
                        check("data_kept", int'(data), int'(last_good));
                    end
                end
            end
        end
        done_prev = reset_n & done;
        ferr_prev = reset_n & frame_err;
    endtask

    // Drive one 8N1 frame; bit_set is scrambled after the start bit to prove it is latched.
    task automatic send(input logic [7:0] b, input int bs, input bit stop_ok, input int gap);
        exp_t e;
        int   bt;
        bt = ref_bit_time(bs);
        @(negedge clk);
        bit_set = 3'(bs);
        e.b     = b;
        e.err   = !stop_ok;
        e.start = cyc;
        e.lat   = 2 + bt / 2 + 9 * bt + 1;
        q.push_back(e);
        uart_rx = 1'b0;
        repeat (bt) @(negedge clk);
        bit_set = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (bt) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (bt - 1) @(negedge clk);
        if (gap > 0) begin
            @(negedge clk);
            uart_rx = 1'b1;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int bt;
        bit ok;
        int gap;
        reset_n = 1'b0;
        uart_rx = 1'b1;
        bit_set = 3'd0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset with a toggling line
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            uart_rx = 1'($urandom_range(0, 1));
        end
        check("rst_data", int'(data), 0);
        check("rst_done", int'(done), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        send(8'h55, 0, 1'b1, 20);
        drain(50);
        check("data_55", int'(data), 8'h55);

        // Back-to-back at 115200
        send(8'hA3, 4, 1'b1, 0);
        send(8'h0F, 4, 1'b1, 20);
        drain(50);
        check("data_0f", int'(data), 8'h0F);

        // Short low pulse shorter than half a bit: rejected as glitch
        @(negedge clk);
        bit_set = 3'd0;
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * ref_bit_time(0)) @(negedge clk);
        check("glitch_busy", int'(busy), 0);
        send(8'h3C, 0, 1'b1, 20);
        drain(50);

        // Bad stop bit
        send(8'hFF, 1, 1'b0, ref_bit_time(1));
        drain(50);
        check("ferr_data_kept", int'(data), 8'h3C);

        // Selects 5..7 alias 9600
        send(8'h81, 7, 1'b1, 20);
        drain(50);

        // Reset mid-DATA
        bt = ref_bit_time(4);
        @(negedge clk);
        bit_set = 3'd4;
        uart_rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'($urandom_range(0, 1));
            repeat (bt) @(negedge clk);
        end
        check("mid_busy", int'(busy), 1);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data", int'(data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        reset_n   = 1'b1;
        last_good = 8'h00;
        repeat (2 * bt) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        send(8'hC6, 4, 1'b1, 20);
        drain(50);

        // Randomised frames
        for (int i = 0; i < 12; i++) begin
            bt  = $urandom_range(0, 7);
            ok  = ($urandom_range(0, 6) != 0);
            gap = ok ? (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 200)))
                     : ref_bit_time(int'(bt));
            send(8'($urandom_range(0, 255)), int'(bt), ok, gap);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        drain(100);
        repeat (20) @(negedge clk);
        check("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
